// File: rtl/thermal_governor_pkg.sv
// Shared types and defaults for the thermal governor: FSM state encoding,
// temperature thresholds and fan duty constants.
package thermal_gov_pkg;

  typedef enum logic [2:0] {
    NORMAL   = 3'd0,
    WARM     = 3'd1,
    THROTTLE = 3'd2,
    SHUTDOWN = 3'd3,
    COOLDOWN = 3'd4
  } gov_state_e;

  localparam logic [7:0]  DEF_T_WARM  = 8'd90;
  localparam logic [7:0]  DEF_T_HOT   = 8'd110;
  localparam logic [7:0]  DEF_T_CRIT  = 8'd125;
  localparam logic [7:0]  DEF_HYST    = 8'd5;
  localparam logic [7:0]  DEF_F_MAX   = 8'd100;
  localparam logic [7:0]  DEF_F_MIN   = 8'd20;
  localparam logic [7:0]  DEF_F_STEP  = 8'd1;
  localparam logic [15:0] DEF_P_LIMIT = 16'd3000;

  localparam logic [7:0] DUTY_IDLE      = 8'h40;
  localparam logic [7:0] DUTY_WARM_BASE = 8'h80;
  localparam logic [7:0] DUTY_FULL      = 8'hFF;

  // WARM fan duty rises 4 codes per degree above t_warm; below t_warm (inside
  // the hysteresis band) it stays at the base duty.
  function automatic logic [7:0] warm_duty(input logic [7:0] temp, input logic [7:0] t_warm);
    logic [9:0] w_sum;
    if (temp < t_warm) return DUTY_WARM_BASE;
    w_sum = 10'(DUTY_WARM_BASE) + (10'(temp - t_warm) << 2);
    return (w_sum > 10'd255) ? DUTY_FULL : w_sum[7:0];
  endfunction

endpackage

// File: rtl/thermal_governor_if.sv
// Sensor inputs and control outputs of the thermal governor, bundled as one
// interface; the governor is the slave, its environment the master.
interface thermal_governor_if;
  import thermal_gov_pkg::*;

  logic [7:0]  temperature;
  logic        throttle_request;
  logic [15:0] power_consumption;
  logic        fault_clr;
  logic [7:0]  freq_code;
  logic        fan_pwm;
  logic [7:0]  fan_duty;
  logic        hash_enable;
  gov_state_e  gov_state;
  logic        fault;

  modport master (
    output temperature, throttle_request, power_consumption, fault_clr,
    input  freq_code, fan_pwm, fan_duty, hash_enable, gov_state, fault
  );

  modport slave (
    input  temperature, throttle_request, power_consumption, fault_clr,
    output freq_code, fan_pwm, fan_duty, hash_enable, gov_state, fault
  );
endinterface

// File: rtl/thermal_governor_fan_pwm_gen.sv
// 8-bit fan PWM: free-running counter, duty reloaded only at counter wrap so
// a duty change never produces a runt pulse.
module fan_pwm_gen
  import thermal_gov_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_duty_target,
  output logic [7:0] o_duty,
  output logic       o_pwm
);

  logic [7:0] r_cnt;
  logic [7:0] r_duty;
  logic       r_pwm;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 8'd0;
      r_duty <= DUTY_IDLE;
      r_pwm  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
      if (r_cnt == 8'hFF) r_duty <= i_duty_target;
      // Full-scale duty is held solid high; zero duty falls out of the compare.
      r_pwm <= (r_duty == DUTY_FULL) || (r_cnt < r_duty);
    end
  end

  assign o_duty = r_duty;
  assign o_pwm  = r_pwm;

endmodule

// File: rtl/thermal_governor.sv
// Hysteretic thermal governor: samples temperature/throttle/power once per
// SAMPLE_DIV clocks and drives PLL frequency code, fan duty and hash enable.
module thermal_governor
  import thermal_gov_pkg::*;
#(
  parameter int          SAMPLE_DIV       = 256,
  parameter logic [7:0]  T_WARM           = DEF_T_WARM,
  parameter logic [7:0]  T_HOT            = DEF_T_HOT,
  parameter logic [7:0]  T_CRIT           = DEF_T_CRIT,
  parameter logic [7:0]  HYST             = DEF_HYST,
  parameter logic [7:0]  F_MAX            = DEF_F_MAX,
  parameter logic [7:0]  F_MIN            = DEF_F_MIN,
  parameter logic [7:0]  F_STEP           = DEF_F_STEP,
  parameter logic [15:0] P_LIMIT          = DEF_P_LIMIT,
  parameter logic [7:0]  COOLDOWN_SAMPLES = 8'd16
) (
  input  logic               clk,
  input  logic               reset,
  thermal_governor_if.slave  bus
);

  localparam int               DIV_W      = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [7:0]       T_WARM_LO  = T_WARM - HYST;
  localparam logic [7:0]       T_HOT_LO   = T_HOT - HYST;
  localparam logic [8:0]       DERATE_MIN = 9'(F_MIN) + 9'(F_STEP);

  logic [DIV_W-1:0] r_div;
  gov_state_e       r_state;
  logic [7:0]       r_cd;
  logic [7:0]       r_freq;
  logic [7:0]       r_duty_tgt;
  logic             r_hash_en;
  logic             r_fault;

  logic             w_tick;
  gov_state_e       w_next;
  logic [7:0]       w_cd_next;
  logic [7:0]       w_ftgt;
  logic [7:0]       w_freq_next;
  logic [7:0]       w_duty_tgt;

  // Inputs are only looked at on the tick cycle, so the live values at that
  // edge are the sample.
  assign w_tick = (r_div == DIV_LAST);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    w_cd_next = r_cd;
    if (bus.temperature >= T_CRIT) begin
      w_next = SHUTDOWN;
    end else begin
      case (r_state)
        NORMAL:   if (bus.temperature >= T_WARM) w_next = WARM;
        WARM:     if (bus.temperature >= T_HOT || bus.throttle_request) w_next = THROTTLE;
                  else if (bus.temperature < T_WARM_LO) w_next = NORMAL;
        THROTTLE: if (bus.temperature < T_HOT_LO && !bus.throttle_request) w_next = WARM;
        SHUTDOWN: if (bus.temperature < T_HOT_LO) begin
                    w_next    = COOLDOWN;
                    w_cd_next = COOLDOWN_SAMPLES;
                  end
        COOLDOWN: if (bus.temperature >= T_HOT) w_next = SHUTDOWN;
                  else if (r_cd <= 8'd1) begin
                    w_next    = NORMAL;
                    w_cd_next = 8'd0;
                  end else w_cd_next = r_cd - 8'd1;
        default:  w_next = NORMAL;
      endcase
    end
  end

  always_comb begin
    w_ftgt     = 8'd0;
    w_duty_tgt = DUTY_FULL;
    case (w_next)
      NORMAL, WARM: begin
        if (bus.power_consumption > P_LIMIT)
          w_ftgt = ({1'b0, r_freq} >= DERATE_MIN) ? r_freq - F_STEP : F_MIN;
        else
          w_ftgt = F_MAX;
        w_duty_tgt = (w_next == NORMAL) ? DUTY_IDLE : warm_duty(bus.temperature, T_WARM);
      end
      THROTTLE, COOLDOWN: w_ftgt = F_MIN;
      default:            w_ftgt = 8'd0;
    endcase

    // Slew toward the target, snapping when closer than one step.
    if (w_next == SHUTDOWN)   w_freq_next = 8'd0;
    else if (w_ftgt > r_freq) w_freq_next = (w_ftgt - r_freq < F_STEP) ? w_ftgt : r_freq + F_STEP;
    else if (w_ftgt < r_freq) w_freq_next = (r_freq - w_ftgt < F_STEP) ? w_ftgt : r_freq - F_STEP;
    else                      w_freq_next = r_freq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= '0;
      r_state    <= NORMAL;
      r_cd       <= 8'd0;
      r_freq     <= F_MIN;
      r_duty_tgt <= DUTY_IDLE;
      r_hash_en  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        r_state    <= w_next;
        r_cd       <= w_cd_next;
        r_freq     <= w_freq_next;
        r_duty_tgt <= w_duty_tgt;
        r_hash_en  <= !(w_next inside {SHUTDOWN, COOLDOWN});
      end
      // Entering SHUTDOWN must win over a clear arriving on the same edge.
      if (w_tick && w_next == SHUTDOWN)             r_fault <= 1'b1;
      else if (bus.fault_clr && r_state != SHUTDOWN) r_fault <= 1'b0;
    end
  end

  fan_pwm_gen u_fan_pwm (
    .clk           (clk),
    .reset         (reset),
    .i_duty_target (r_duty_tgt),
    .o_duty        (bus.fan_duty),
    .o_pwm         (bus.fan_pwm)
  );

  assign bus.freq_code   = r_freq;
  assign bus.hash_enable = r_hash_en;
  assign bus.gov_state   = r_state;
  assign bus.fault       = r_fault;

endmodule

// File: tb/tb_thermal_governor.sv
// Self-checking bench for thermal_governor: directed scenarios plus random
// sensor traffic, compared every cycle against a behavioural model.
module tb_thermal_governor;
  import thermal_gov_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  thermal_governor_if bus();

  thermal_governor #(
    .SAMPLE_DIV       (4),
    .COOLDOWN_SAMPLES (8'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state: edges since reset release, governor outputs.
  int         m_n;
  gov_state_e m_state;
  int         m_freq, m_duty, m_duty_tgt, m_cd_left;
  bit         m_hash, m_fault, m_pwm;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_state = NORMAL; m_freq = 20; m_duty = 64; m_duty_tgt = 64;
    m_cd_left = 0; m_hash = 0; m_fault = 0; m_pwm = 0;
  endtask

  // One sample tick: apply the governor rules to the sampled inputs.
  task automatic model_tick(output bit set_fault);
    int t, p, tg;
    bit thr;
    gov_state_e nx;
    t = int'(bus.temperature); p = int'(bus.power_consumption); thr = bus.throttle_request;
    nx = m_state;
    if (t >= 125) nx = SHUTDOWN;
    else case (m_state)
      NORMAL:   if (t >= 90) nx = WARM;
      WARM:     if (t >= 110 || thr) nx = THROTTLE; else if (t < 85) nx = NORMAL;
      THROTTLE: if (t < 105 && !thr) nx = WARM;
      SHUTDOWN: if (t < 105) begin nx = COOLDOWN; m_cd_left = 3; end
      default:  if (t >= 110) nx = SHUTDOWN;
                else begin
                  m_cd_left--;
                  if (m_cd_left == 0) nx = NORMAL;
                end
    endcase
    if (nx == NORMAL || nx == WARM) tg = (p > 3000) ? ((m_freq - 1 > 20) ? m_freq - 1 : 20) : 100;
    else if (nx == SHUTDOWN)        tg = 0;
    else                            tg = 20;
    if (nx == SHUTDOWN)     m_freq = 0;
    else if (m_freq < tg)   m_freq++;
    else if (m_freq > tg)   m_freq--;
    if (nx == NORMAL)       m_duty_tgt = 64;
    else if (nx == WARM)    m_duty_tgt = (t < 90) ? 128 : ((128 + 4 * (t - 90) > 255) ? 255 : 128 + 4 * (t - 90));
    else                    m_duty_tgt = 255;
    m_hash    = !(nx == SHUTDOWN || nx == COOLDOWN);
    set_fault = (nx == SHUTDOWN);
    m_state   = nx;
  endtask

  task automatic model_edge();
    int cnt_before;
    bit clr_ok, set_fault;
    cnt_before = m_n % 256;
    clr_ok     = bus.fault_clr && (m_state != SHUTDOWN);
    m_pwm      = (m_duty == 255) || (cnt_before < m_duty);
    if (cnt_before == 255) m_duty = m_duty_tgt;
    m_n++;
    set_fault = 1'b0;
    if (m_n % 4 == 0) model_tick(set_fault);
    if (set_fault)   m_fault = 1'b1;
    else if (clr_ok) m_fault = 1'b0;
  endtask

  task automatic check_all();
    check("freq_code",   16'(bus.freq_code),   16'(m_freq));
    check("fan_duty",    16'(bus.fan_duty),    16'(m_duty));
    check("fan_pwm",     16'(bus.fan_pwm),     16'(m_pwm));
    check("hash_enable", 16'(bus.hash_enable), 16'(m_hash));
    check("gov_state",   16'(bus.gov_state),   16'(m_state));
    check("fault",       16'(bus.fault),       16'(m_fault));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_ticks(input int k);
    repeat (k * 4) cycle();
  endtask

  // Called at a falling edge: reset is asserted mid-cycle and must act at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_freq_now",  16'(bus.freq_code),   16'd20);
    check("rst_state_now", 16'(bus.gov_state),   16'(NORMAL));
    check("rst_hash_now",  16'(bus.hash_enable), 16'd0);
    check("rst_fault_now", 16'(bus.fault),       16'd0);
    check("rst_duty_now",  16'(bus.fan_duty),    16'h40);
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    bus.temperature = 8'd60; bus.throttle_request = 1'b0;
    bus.power_consumption = 16'd2000; bus.fault_clr = 1'b0;
    do_reset();

    // Soft start: hashing enabled at first tick, ramp 20 -> 100.
    run_ticks(1);
    check("first_tick_hash", 16'(bus.hash_enable), 16'd1);
    check("first_tick_freq", 16'(bus.freq_code),   16'd21);
    run_ticks(84);
    check("ramp_top", 16'(bus.freq_code), 16'd100);

    // WARM entry and fan duty after a PWM wrap.
    bus.temperature = 8'd95;
    run_ticks(71);
    check("warm_state", 16'(bus.gov_state), 16'(WARM));
    check("warm_duty",  16'(bus.fan_duty),  16'h94);
    bus.temperature = 8'd88;
    run_ticks(5);
    check("warm_hyst_hold", 16'(bus.gov_state), 16'(WARM));
    bus.temperature = 8'd84;
    run_ticks(1);
    check("warm_to_normal", 16'(bus.gov_state), 16'(NORMAL));

    // Throttle request ramps down to floor; release ramps back up.
    bus.temperature = 8'd95;
    run_ticks(1);
    bus.throttle_request = 1'b1;
    run_ticks(1);
    check("throttle_state", 16'(bus.gov_state), 16'(THROTTLE));
    run_ticks(85);
    check("throttle_floor", 16'(bus.freq_code), 16'd20);
    bus.throttle_request = 1'b0; bus.temperature = 8'd104;
    run_ticks(10);
    check("rewarm_state", 16'(bus.gov_state), 16'(WARM));
    check("rewarm_freq",  16'(bus.freq_code), 16'd30);

    // Critical temperature from NORMAL at full speed.
    bus.temperature = 8'd60;
    run_ticks(76);
    check("normal_full", 16'(bus.freq_code), 16'd100);
    bus.temperature = 8'd126;
    run_ticks(1);
    check("sd_state", 16'(bus.gov_state),   16'(SHUTDOWN));
    check("sd_freq",  16'(bus.freq_code),   16'd0);
    check("sd_hash",  16'(bus.hash_enable), 16'd0);
    check("sd_fault", 16'(bus.fault),       16'd1);
    bus.fault_clr = 1'b1;
    run_ticks(2);
    bus.temperature = 8'd120;
    run_ticks(2);
    check("sd_clr_ignored", 16'(bus.fault), 16'd1);
    bus.fault_clr = 1'b0;

    // Cooldown lasts three ticks, then fault can be cleared.
    bus.temperature = 8'd100;
    run_ticks(3);
    check("cooldown_state", 16'(bus.gov_state), 16'(COOLDOWN));
    run_ticks(1);
    check("cooldown_done", 16'(bus.gov_state),   16'(NORMAL));
    check("cooldown_hash", 16'(bus.hash_enable), 16'd1);
    bus.fault_clr = 1'b1;
    cycle();
    bus.fault_clr = 1'b0;
    check("fault_cleared", 16'(bus.fault), 16'd0);

    // Re-heating during cooldown goes back to SHUTDOWN.
    bus.temperature = 8'd126; run_ticks(1);
    bus.temperature = 8'd100; run_ticks(1);
    bus.temperature = 8'd112; run_ticks(1);
    check("cd_reheat", 16'(bus.gov_state), 16'(SHUTDOWN));

    // Power derating from full speed, then reset in the middle of the ramp.
    bus.temperature = 8'd100; run_ticks(3);
    bus.temperature = 8'd60;  run_ticks(100);
    bus.power_consumption = 16'd3500;
    run_ticks(30);
    check("derate_freq", 16'(bus.freq_code), 16'd70);
    do_reset();
    bus.power_consumption = 16'd2000;

    // Random sensor traffic; inputs change once per sample period.
    for (int i = 0; i < 400; i++) begin
      bus.temperature       = 8'($urandom_range(60, 130));
      bus.throttle_request  = ($urandom_range(0, 3) == 0);
      bus.power_consumption = 16'($urandom_range(1500, 4000));
      for (int c = 0; c < 4; c++) begin
        bus.fault_clr = ($urandom_range(0, 7) == 0);
        cycle();
      end
    end
    bus.fault_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
